// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the instruction store and its byte-serial loader.
//   ADDRESS_SIZE     : width of the fetch address and of the load length
//   INSTRUCTION_SIZE : instruction word width (a multiple of 8)
//   NOP_INST         : word returned for out-of-range fetches or while loading
//   imem_state_e     : loader FSM state encodings
package instruction_memory_pkg;

  localparam int unsigned ADDRESS_SIZE     = 16;
  localparam int unsigned INSTRUCTION_SIZE = 32;

  localparam logic [INSTRUCTION_SIZE-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_IDLE   = 2'd0,
    IMEM_LOAD   = 2'd1,
    IMEM_FINISH = 2'd2
  } imem_state_e;

endpackage

// File: rtl/instruction_memory_load_assembler.sv
// Little-endian byte-to-word assembler for the program loader.
//   clock, reset : clock and synchronous active-low reset
//   data         : incoming byte
//   strobe       : data is transferred this cycle
//   clear        : restart assembly at beat 0 with an empty register
//   word         : assembled word, including the byte on the current strobe
//   word_valid   : pulse on the strobe that carries the final beat
module instruction_memory_load_assembler #(
  parameter int unsigned BEATS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         data,
  input  logic               strobe,
  input  logic               clear,
  output logic [8*BEATS-1:0] word,
  output logic               word_valid
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BW-1:0]      beat_q, beat_d;
  logic [8*BEATS-1:0] asm_q, asm_d;
  logic               last_beat;

  assign last_beat  = (beat_q == BW'(BEATS - 1));
  assign word_valid = strobe && last_beat;

  // The final byte is merged combinationally so the word can be written on
  // the same edge that delivers it.
  always_comb begin
    word = asm_q;
    word[8*(BEATS-1) +: 8] = data;
  end

  always_comb begin
    beat_d = beat_q;
    asm_d  = asm_q;
    if (clear) begin
      beat_d = '0;
      asm_d  = '0;
    end else if (strobe) begin
      asm_d[8*beat_q +: 8] = data;
      beat_d = last_beat ? '0 : beat_q + BW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      beat_q <= '0;
      asm_q  <= '0;
    end else begin
      beat_q <= beat_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction store with a byte-serial program loader.
//   clock, reset : clock and synchronous active-low reset
//   pc           : fetch address; instruction is mem[pc] combinationally
//   instruction  : fetched word, NOP_INST when out of range or loading
//   load_start   : pulse beginning a load of load_length words (IDLE only)
//   load_byte/valid/ready : byte stream, little-endian within each word
//   cpu_hold     : stall request to the core while loading
//   load_done    : one-cycle pulse when a load completes
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned BEATS = INSTRUCTION_SIZE / 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDRESS_SIZE-1:0]     pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                        load_start,
  input  logic [ADDRESS_SIZE-1:0]     load_length,
  input  logic [7:0]                  load_byte,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic                        cpu_hold,
  output logic                        load_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_e state_q, state_d;

  logic [ADDRESS_SIZE-1:0]     length_q, length_d;
  logic [ADDRESS_SIZE-1:0]     count_q, count_d;
  logic [AW-1:0]               ptr_q, ptr_d;
  logic                        asm_clear;
  logic                        asm_strobe;
  logic [INSTRUCTION_SIZE-1:0] asm_word;
  logic                        asm_word_valid;
  logic                        last_word;

  logic [INSTRUCTION_SIZE-1:0] mem [DEPTH];

  // Gate the strobe with reset so a final beat landing on a reset edge is
  // not written.
  assign asm_strobe = load_valid && load_ready && reset;
  assign last_word  = asm_word_valid && ((count_q + ADDRESS_SIZE'(1)) == length_q);

  instruction_memory_load_assembler #(
    .BEATS (BEATS)
  ) u_load_assembler (
    .clock      (clock),
    .reset      (reset),
    .data       (load_byte),
    .strobe     (asm_strobe),
    .clear      (asm_clear),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    asm_clear  = 1'b0;
    load_ready = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    unique case (state_q)
      IMEM_IDLE: begin
        if (load_start) begin
          asm_clear = 1'b1;
          length_d  = load_length;
          count_d   = '0;
          ptr_d     = '0;
          state_d   = (load_length == '0) ? IMEM_FINISH : IMEM_LOAD;
        end
      end
      IMEM_LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (asm_word_valid) begin
          count_d = count_q + ADDRESS_SIZE'(1);
          ptr_d   = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
        if (last_word) begin
          state_d = IMEM_FINISH;
        end
      end
      IMEM_FINISH: begin
        cpu_hold  = 1'b1;
        load_done = 1'b1;
        state_d   = IMEM_IDLE;
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IMEM_IDLE;
      length_q <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
    end
  end

  // Storage is deliberately never reset or cleared.
  always_ff @(posedge clock) begin
    if (asm_word_valid) begin
      mem[ptr_q] <= asm_word;
    end
  end

  logic [ADDRESS_SIZE:0] pc_ext;
  assign pc_ext = {1'b0, pc};

  always_comb begin
    instruction = NOP_INST;
    if ((state_q == IMEM_IDLE) && (pc_ext < (ADDRESS_SIZE + 1)'(DEPTH))) begin
      instruction = mem[pc[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;
  import instruction_memory_pkg::*;

  logic                        clock;
  logic                        reset;
  logic [ADDRESS_SIZE-1:0]     pc;
  logic [INSTRUCTION_SIZE-1:0] instruction;
  logic                        load_start;
  logic [ADDRESS_SIZE-1:0]     load_length;
  logic [7:0]                  load_byte;
  logic                        load_valid;
  logic                        load_ready;
  logic                        cpu_hold;
  logic                        load_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] bytes [16];

  instruction_memory #(
    .DEPTH (256)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction),
    .load_start  (load_start),
    .load_length (load_length),
    .load_byte   (load_byte),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_word(input int addr, output logic [31:0] w);
    pc = ADDRESS_SIZE'(addr);
    #1;
    w = instruction;
  endtask

  // Runs one load. Returns the number of cycles from the start edge until
  // load_done is seen (-1 if never seen). restart_cyc pulses load_start
  // mid-load; abort_after asserts reset once that many bytes were sent.
  task automatic run_load(input int len, input int nb, input bit stall,
                          input int restart_cyc, input int abort_after,
                          output int done_cyc, output bit hold_ok, output bit nop_ok);
    int idx = 0;
    int cyc = 0;
    bit xfer;
    done_cyc = -1;
    hold_ok  = 1'b1;
    nop_ok   = 1'b1;
    load_start  = 1'b1;
    load_length = ADDRESS_SIZE'(len);
    load_byte   = bytes[0];
    load_valid  = 1'b1;  // presented with start; must not be taken
    pc          = '0;
    step();
    load_start = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (load_done) begin
        done_cyc = cyc;
        break;
      end
      if (cpu_hold !== 1'b1) hold_ok = 1'b0;
      if (instruction !== NOP_INST) nop_ok = 1'b0;
      if (abort_after >= 0 && idx == abort_after) begin
        load_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        break;
      end
      load_start  = (cyc == restart_cyc);
      load_length = 16'd5;
      load_valid  = (idx < nb) && (!stall || (cyc % 2 == 1));
      load_byte   = bytes[idx % 16];
      #1;
      xfer = load_valid && load_ready;
      step();
      if (xfer) idx++;
      cyc++;
    end
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    int dc;
    bit hold_ok, nop_ok;
    logic [31:0] w;

    reset = 1'b0; pc = '0; load_start = 1'b0; load_length = '0;
    load_byte = '0; load_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    // Reset state.
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_hold",  {31'b0, cpu_hold},   32'd0);
    chk("rst_done",  {31'b0, load_done},  32'd0);
    read_word(300, w);
    chk("rst_pc300_nop", w, 32'h0000_0013);

    // Basic continuous load of two words.
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    bytes[4] = 8'hEF; bytes[5] = 8'hBE; bytes[6] = 8'hAD; bytes[7] = 8'hDE;
    run_load(2, 8, 1'b0, -1, -1, dc, hold_ok, nop_ok);
    chk("basic_done_cyc", dc, 32'd9);
    chk("basic_hold",   {31'b0, hold_ok}, 32'd1);
    chk("basic_nop",    {31'b0, nop_ok},  32'd1);
    chk("finish_ready", {31'b0, load_ready}, 32'd0);
    step();
    chk("post_hold", {31'b0, cpu_hold},  32'd0);
    chk("post_done", {31'b0, load_done}, 32'd0);
    read_word(0, w); chk("basic_w0", w, 32'h1234_5678);
    read_word(1, w); chk("basic_w1", w, 32'hDEAD_BEEF);

    // Stalled handshake, new data overwrites the same addresses.
    bytes[0] = 8'h44; bytes[1] = 8'h33; bytes[2] = 8'h22; bytes[3] = 8'h11;
    bytes[4] = 8'h88; bytes[5] = 8'h77; bytes[6] = 8'h66; bytes[7] = 8'h55;
    run_load(2, 8, 1'b1, -1, -1, dc, hold_ok, nop_ok);
    chk("stall_done_cyc", dc, 32'd16);
    chk("stall_hold", {31'b0, hold_ok}, 32'd1);
    step();
    read_word(0, w); chk("stall_w0", w, 32'h1122_3344);
    read_word(1, w); chk("stall_w1", w, 32'h5566_7788);
    read_word(300, w); chk("idle_pc300_nop", w, 32'h0000_0013);

    // Zero length goes straight to FINISH and writes nothing.
    load_start = 1'b1; load_length = '0; pc = '0;
    step();
    load_start = 1'b0;
    chk("zero_done", {31'b0, load_done},  32'd1);
    chk("zero_hold", {31'b0, cpu_hold},   32'd1);
    chk("zero_ready", {31'b0, load_ready}, 32'd0);
    step();
    chk("zero_idle_done", {31'b0, load_done}, 32'd0);
    read_word(0, w); chk("zero_w0", w, 32'h1122_3344);

    // Restart pulse mid-load is ignored; one word completes.
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
    run_load(1, 4, 1'b0, 2, -1, dc, hold_ok, nop_ok);
    chk("restart_done_cyc", dc, 32'd5);
    step();
    chk("restart_idle_hold", {31'b0, cpu_hold}, 32'd0);
    read_word(0, w); chk("restart_w0", w, 32'h0403_0201);
    read_word(1, w); chk("restart_w1", w, 32'h5566_7788);

    // Reset after six bytes of a two-word load.
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    bytes[4] = 8'hEF; bytes[5] = 8'hBE; bytes[6] = 8'hAD; bytes[7] = 8'hDE;
    run_load(2, 8, 1'b0, -1, 6, dc, hold_ok, nop_ok);
    chk("abort_no_done", dc, 32'hFFFF_FFFF);
    chk("abort_hold",  {31'b0, cpu_hold},   32'd0);
    chk("abort_ready", {31'b0, load_ready}, 32'd0);
    step();
    chk("abort_done_later", {31'b0, load_done}, 32'd0);
    read_word(0, w); chk("abort_w0", w, 32'h1234_5678);
    read_word(1, w); chk("abort_w1", w, 32'h5566_7788);

    // Fresh load after the abort starts at address 0, beat 0.
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    run_load(1, 4, 1'b0, -1, -1, dc, hold_ok, nop_ok);
    chk("fresh_done_cyc", dc, 32'd5);
    step();
    read_word(0, w); chk("fresh_w0", w, 32'hDDCC_BBAA);
    read_word(1, w); chk("fresh_w1", w, 32'h5566_7788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
